// File: rtl/mpt_pkg.sv
// Shared MPT definitions: address/SDID widths, permission and access
// encodings, the walker-facing PLB request/entry records and the PLB
// response record, plus helpers used by the lookaside buffer.
package mpt_pkg;

   localparam int XLEN        = 32;
   localparam int SDID_LEN    = 6;
   localparam int PAGE_LEN    = XLEN - 12;
   localparam int PLB_TAG_LEN = SDID_LEN + XLEN - 12;

   // PERMS bit 0 = read, bit 1 = write, bit 2 = execute
   typedef enum logic [2:0] {
      ALLOW_NONE = 3'b000,
      ALLOW_R    = 3'b001,
      ALLOW_W    = 3'b010,
      ALLOW_RW   = 3'b011,
      ALLOW_X    = 3'b100,
      ALLOW_RX   = 3'b101,
      ALLOW_WX   = 3'b110,
      ALLOW_RWX  = 3'b111
   } mpt_permissions_e;

   typedef enum logic [1:0] {
      ACCESS_NONE    = 2'd0,
      ACCESS_READ    = 2'd1,
      ACCESS_WRITE   = 2'd2,
      ACCESS_EXECUTE = 2'd3
   } mpt_access_e;

   typedef struct packed {
      logic [SDID_LEN-1:0] sdid;
      logic [XLEN-1:0]     spa;
      mpt_permissions_e    perms;
   } plb_entry_t;

   typedef struct packed {
      logic [SDID_LEN-1:0] sdid;
      logic [XLEN-1:0]     spa;
      mpt_access_e         access_type;
   } plb_lookup_req_t;

   typedef struct packed {
      logic       hit;
      logic       allow;
      logic [2:0] perms;
   } plb_rsp_t;

   // True when the permission set grants the requested kind of access
   function automatic logic mpt_perm_ok(input mpt_permissions_e perms,
                                        input mpt_access_e      access);
      logic [2:0] perm_bits;
      logic       ok;
      perm_bits = perms;
      case (access)
         ACCESS_READ:    ok = perm_bits[0];
         ACCESS_WRITE:   ok = perm_bits[1];
         ACCESS_EXECUTE: ok = perm_bits[2];
         default:        ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Tag is the SDID concatenated with the page number (offset dropped)
   function automatic logic [PLB_TAG_LEN-1:0] plb_tag(input logic [SDID_LEN-1:0] sdid,
                                                      input logic [PAGE_LEN-1:0] page);
      return {sdid, page};
   endfunction

endpackage

// File: rtl/mpt_plb_victim_sel.sv
// Fill slot selection for the PLB: an existing entry with the same tag wins,
// otherwise the lowest free slot, otherwise the round-robin victim. The
// round-robin pointer only advances when a fill actually evicts.
module mpt_plb_victim_sel #(
   parameter int NUM_ENTRIES = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_ENTRIES-1:0]         valid_i,
   input  logic [NUM_ENTRIES-1:0]         match_i,
   input  logic                           fill_en_i,
   output logic [$clog2(NUM_ENTRIES)-1:0] fill_idx_o
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] match_idx;
   logic [IDX_W-1:0] rr_q;
   logic             any_free;
   logic             any_match;
   logic             evict;

   // Find-first-invalid: scan downwards so the lowest free index wins
   always_comb begin
      free_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_i[i]) begin
            free_idx = IDX_W'(i);
         end
      end
   end

   // Index of the entry already holding the fill tag (at most one matches)
   always_comb begin
      match_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (match_i[i]) begin
            match_idx = IDX_W'(i);
         end
      end
   end

   assign any_free  = ~&valid_i;
   assign any_match = |match_i;
   assign evict     = fill_en_i && !any_match && !any_free;

   // Slot priority: in-place update, then free slot, then round-robin victim
   always_comb begin
      if (any_match) begin
         fill_idx_o = match_idx;
      end else if (any_free) begin
         fill_idx_o = free_idx;
      end else begin
         fill_idx_o = rr_q;
      end
   end

   // Round-robin pointer steps only on eviction and wraps at the last entry
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q <= '0;
      end else if (evict) begin
         if (rr_q == IDX_W'(NUM_ENTRIES - 1)) begin
            rr_q <= '0;
         end else begin
            rr_q <= rr_q + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/mpt_plb.sv
// Protection Lookaside Buffer: fully associative cache of {SDID, page, PERMS}
// filled by the MPT walker. Lookups get a registered hit/allow/perms answer
// one cycle after acceptance; flushes (all or per SDID) take effect in one
// cycle and never stall lookups.
module mpt_plb
   import mpt_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int CNT_W       = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                lkp_valid_i,
   output logic                lkp_ready_o,
   input  plb_lookup_req_t     lkp_req_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic                rsp_hit_o,
   output logic                rsp_allow_o,
   output logic [2:0]          rsp_perms_o,
   input  logic                fill_valid_i,
   input  plb_entry_t          fill_entry_i,
   input  logic                flush_all_i,
   input  logic                flush_sdid_i,
   input  logic [SDID_LEN-1:0] flush_sdid_val_i,
   output logic [CNT_W-1:0]    hit_cnt_o,
   output logic [CNT_W-1:0]    miss_cnt_o
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   logic [NUM_ENTRIES-1:0]                  entry_valid;
   logic [NUM_ENTRIES-1:0][PLB_TAG_LEN-1:0] entry_tag;
   logic [NUM_ENTRIES-1:0][2:0]             entry_perms;

   logic [PLB_TAG_LEN-1:0] lkp_tag;
   logic [PLB_TAG_LEN-1:0] fill_tag;
   logic [NUM_ENTRIES-1:0] flush_mask;
   logic [NUM_ENTRIES-1:0] valid_post_flush;
   logic [NUM_ENTRIES-1:0] fill_match;
   logic [NUM_ENTRIES-1:0] fill_onehot;
   logic [IDX_W-1:0]       fill_idx;
   logic                   fill_en;
   logic                   accept;
   plb_rsp_t               lkp_rsp;
   plb_rsp_t               rsp_q;
   logic                   rsp_valid_q;
   logic [CNT_W-1:0]       hit_cnt_q;
   logic [CNT_W-1:0]       miss_cnt_q;
   logic                   unused_offset_bits;

   // Page offsets never participate in matching
   assign unused_offset_bits = ^{lkp_req_i.spa[11:0], fill_entry_i.spa[11:0]};

   assign lkp_tag  = plb_tag(lkp_req_i.sdid, lkp_req_i.spa[XLEN-1:12]);
   assign fill_tag = plb_tag(fill_entry_i.sdid, fill_entry_i.spa[XLEN-1:12]);

   assign lkp_ready_o = !rsp_valid_q || rsp_ready_i;
   assign accept      = lkp_valid_i && lkp_ready_o;

   // Parallel tag compare against the current (pre-update) array
   always_comb begin
      lkp_rsp = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (entry_valid[i] && (entry_tag[i] == lkp_tag)) begin
            lkp_rsp.hit   = 1'b1;
            lkp_rsp.perms = lkp_rsp.perms | entry_perms[i];
         end
      end
      lkp_rsp.allow = lkp_rsp.hit &&
                      mpt_perm_ok(mpt_permissions_e'(lkp_rsp.perms), lkp_req_i.access_type);
   end

   // Entries removed by this cycle's flush; flush_all overrides flush_sdid
   always_comb begin
      flush_mask = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (flush_all_i) begin
            flush_mask[i] = 1'b1;
         end else if (flush_sdid_i &&
                      (entry_tag[i][PLB_TAG_LEN-1 -: SDID_LEN] == flush_sdid_val_i)) begin
            flush_mask[i] = 1'b1;
         end
      end
   end

   assign valid_post_flush = entry_valid & ~flush_mask;

   // Fill placement sees the array as it stands after this cycle's flush
   always_comb begin
      fill_match = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         fill_match[i] = valid_post_flush[i] && (entry_tag[i] == fill_tag);
      end
   end

   // A concurrent flush that covers the fill's SDID cancels the fill
   always_comb begin
      fill_en = fill_valid_i;
      if (flush_all_i) begin
         fill_en = 1'b0;
      end else if (flush_sdid_i && (fill_entry_i.sdid == flush_sdid_val_i)) begin
         fill_en = 1'b0;
      end
   end

   mpt_plb_victim_sel #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_victim_sel (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_post_flush),
      .match_i    (fill_match),
      .fill_en_i  (fill_en),
      .fill_idx_o (fill_idx)
   );

   // One-hot of the slot being written this cycle
   always_comb begin
      fill_onehot = '0;
      if (fill_en) begin
         fill_onehot[fill_idx] = 1'b1;
      end
   end

   // Entry array update: apply flush first, then install the fill
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         entry_valid <= '0;
         entry_tag   <= '0;
         entry_perms <= '0;
      end else begin
         entry_valid <= valid_post_flush | fill_onehot;
         if (fill_en) begin
            entry_tag[fill_idx]   <= fill_tag;
            entry_perms[fill_idx] <= fill_entry_i.perms;
         end
      end
   end

   // Response register: load on accept, hold while stalled, clear on consume
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_q       <= lkp_rsp;
      end else if (rsp_ready_i) begin
         rsp_valid_q <= 1'b0;
      end
   end

   // Saturating hit/miss statistics, one step per accepted lookup
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (accept) begin
         if (lkp_rsp.hit) begin
            if (hit_cnt_q != {CNT_W{1'b1}}) begin
               hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
         end else begin
            if (miss_cnt_q != {CNT_W{1'b1}}) begin
               miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_hit_o   = rsp_q.hit;
   assign rsp_allow_o = rsp_q.allow;
   assign rsp_perms_o = rsp_q.perms;
   assign hit_cnt_o   = hit_cnt_q;
   assign miss_cnt_o  = miss_cnt_q;

endmodule
